mmio_timer_periph: RTL and testbench
====================================

# mmio_timer_periph

Memory-mapped timer/IO peripheral answering the single-cycle CPU's data bus in the 0x4000_0000 window, alongside the data memory. It responds to the CPU's load/store accesses (rd, wr, addr, wdata → rdata) with the same signalling as the data memory. It runs a reloadable 32-bit timer and a free-running tick counter, and drives `IRQsig` back to the control unit when the timer overflows with interrupts enabled.

## Interface
Parameters:
- `BASE` — default 32'h4000_0000 — word-aligned base address of the register window.
- `LED_W` — default 8 — width of the LED output register.
- `SW_W` — default 8 — width of the switch input.

Ports:
- `clk  in  1` — system clock; every register updates on its rising edge.
- `reset  in  1` — asynchronous, active-low reset (driven from `Reset_n`).
- `rd  in  1` — read strobe (MemRd).
- `wr  in  1` — write strobe (MemWr).
- `addr  in  32` — byte address (ALUOut); `addr[1:0]` is ignored.
- `wdata  in  32` — store data (DatabusB).
- `rdata  out  32` — load data; combinational.
- `switch  in  SW_W` — board switches; asynchronous input.
- `led  out  LED_W` — LED register.
- `irqout  out  1` — interrupt request to the control unit (`IRQsig`).

## Operation
Register map (offset from BASE; word index is `addr[4:2]`):
- `0x00 TH` — R/W, 32 bits; reload value.
- `0x04 TL` — R/W, 32 bits; counting register.
- `0x08 TCON` — R/W. Bit 0 EN, bit 1 IE, bit 2 IF; bits 31:3 read 0.
- `0x0C LED` — R/W; bits `LED_W-1:0`.
- `0x10 SW` — read-only; the 2-flop synchronized `switch`, zero-extended.
- `0x14 SYSTICK` — read-only; free-running 32-bit counter.
- Offsets 0x18–0x1C and any address outside `[BASE, BASE+0x1F]` are unmapped.

Timer:
- When EN=1, TL increments by 1 every cycle.
- When TL==32'hFFFF_FFFF and EN=1, the next TL is TH (reload), not 0. That cycle is an overflow event.
- On an overflow event with IE=1, IF is set to 1. With IE=0, IF is unchanged.
- `irqout = IE & IF`, driven from registers (no combinational path from the bus inputs).
- When EN=0, TL holds its value and no overflow event occurs.
- SYSTICK increments every cycle and wraps from FFFF_FFFF to 0. Writes to it are ignored.

Bus rules:
- A write happens on the clock edge where `wr=1` and the address is mapped. Writes to unmapped or read-only addresses have no effect.
- `rdata` = the selected register when `rd=1` and the address is mapped; otherwise 0.
- If `rd` and `wr` are both 1, the write takes effect and `rdata` shows the pre-write value.
- The CPU clears the interrupt by writing TCON with bit 2 = 0.

Simultaneous events:
- CPU write to TL in an overflow cycle: the written value wins over the reload.
- CPU write to TCON in an overflow cycle with the old IE=1: new EN and IE = `wdata[1:0]`; new IF = `wdata[2] | 1`. The hardware set wins, so no interrupt is lost.
- CPU write to TH in an overflow cycle: the reload uses the old TH; the new TH is stored.

## Timing
- Reset values: TH=0, TL=0, TCON=0, LED=0, SYSTICK=0, switch synchronizer=0, `irqout`=0, `led`=0. `rdata` is 0 whenever `rd=0`.
- Reset mid-count clears everything immediately (asynchronous). The first increment occurs on the first clock edge after reset is released.
- Read latency is 0 cycles (combinational, same cycle as the load).
- Write latency: the new value is visible to reads from the next cycle.
- Overflow at edge N: TL=TH and IF=1 after edge N, so `irqout` is high in cycle N+1.
- Timer period with EN=1 is `2^32 − TH` cycles per overflow.
- `switch` reaches SW after 2 cycles.

## Structure
- The shared package holds:
  - register offset constants: `TH_OFS`, `TL_OFS`, `TCON_OFS`, `LED_OFS`, `SW_OFS`, `SYSTICK_OFS`;
  - TCON bit indices: `TCON_EN`, `TCON_IE`, `TCON_IF`;
  - the default `BASE`.
- One sub-module, `sync2`: a parameterized-width 2-flop synchronizer for `switch`, with the same clock and reset.
- Decode, the register file, the timer and SYSTICK all live in the top of this block.

## Test plan
- Reset, then read every mapped register → all return 0, `irqout`=0. Read 0x4000_0020 or 0x1000_0000 → 0. Write to SYSTICK → no change.
- TH=FFFF_FFFC, TL=FFFF_FFFE, TCON=3 → TL reads FFFF_FFFF, then FFFF_FFFC. `irqout` rises exactly one cycle after the reload edge. Write TCON=3 → `irqout` drops the next cycle.
- TCON=1 (IE=0) through an overflow → TL reloads, IF stays 0, `irqout` stays 0.
- Write TCON=3 in the exact overflow cycle → IF=1 and `irqout`=1 afterwards. Write TL=0x10 in the overflow cycle → TL=0x11 next cycle.
- Write LED=0xA5 → `led`=0xA5 after the edge. Set `switch`=0x3C → SW reads 0x3C from the 2nd cycle on.
- Assert reset mid-count with `irqout`=1 → all outputs are 0 immediately. After release, SYSTICK reads 1 after the first edge.

Source files
------------

// File: rtl/mmio_timer_periph_pkg.sv
// Shared constants for the memory-mapped timer/IO peripheral.
// Holds the default window base, the register byte offsets and the TCON bit positions.
// Purely declarative, so there is no latency and no backpressure.
package mmio_timer_periph_pkg;

    // Default base of the 32-byte register window
    localparam logic [31:0] DEFAULT_BASE = 32'h4000_0000;

    // Register byte offsets within the window
    localparam logic [4:0] TH_OFS      = 5'h00;
    localparam logic [4:0] TL_OFS      = 5'h04;
    localparam logic [4:0] TCON_OFS    = 5'h08;
    localparam logic [4:0] LED_OFS     = 5'h0C;
    localparam logic [4:0] SW_OFS      = 5'h10;
    localparam logic [4:0] SYSTICK_OFS = 5'h14;

    // TCON bit positions
    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IF = 2;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer that brings an asynchronous multi-bit input into the clk domain.
// Latency is 2 cycles from a change on d_i to the same value on q_o.
// There is no handshake; q_o is updated on every cycle.
module sync2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Shift the input through two flops; the first one may go metastable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/mmio_timer_periph.sv
// Timer/IO peripheral on the CPU data bus: TH/TL reload timer, TCON, LED, SW and SYSTICK.
// Reads return data in the same cycle (combinational rdata). Writes take effect at the next clock edge.
// There is no backpressure: every access completes in one cycle, and unmapped accesses read 0.
module mmio_timer_periph
    import mmio_timer_periph_pkg::*;
#(
    parameter logic [31:0] BASE  = DEFAULT_BASE,
    parameter int          LED_W = 8,
    parameter int          SW_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd,
    input  logic             wr,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [SW_W-1:0]  switch,
    output logic [LED_W-1:0] led,
    output logic             irqout
);

    localparam logic [2:0] W_TH      = TH_OFS[4:2];
    localparam logic [2:0] W_TL      = TL_OFS[4:2];
    localparam logic [2:0] W_TCON    = TCON_OFS[4:2];
    localparam logic [2:0] W_LED     = LED_OFS[4:2];
    localparam logic [2:0] W_SW      = SW_OFS[4:2];
    localparam logic [2:0] W_SYSTICK = SYSTICK_OFS[4:2];

    logic [31:0]      th_q, th_d;
    logic [31:0]      tl_q, tl_d;
    logic             en_q, en_d;
    logic             ie_q, ie_d;
    logic             if_q, if_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [31:0]      tick_q;
    logic [SW_W-1:0]  sw_sync;

    logic        hit;
    logic [2:0]  widx;
    logic        we_th, we_tl, we_tcon, we_led;
    logic        ovf;
    logic [31:0] tcon_val;
    logic        unused_addr;

    // The byte lane bits are not part of the decode
    assign unused_addr = ^addr[1:0];

    assign hit     = (addr[31:5] == BASE[31:5]);
    assign widx    = addr[4:2];
    assign we_th   = wr && hit && (widx == W_TH);
    assign we_tl   = wr && hit && (widx == W_TL);
    assign we_tcon = wr && hit && (widx == W_TCON);
    assign we_led  = wr && hit && (widx == W_LED);

    // Overflow is the enabled cycle in which TL is about to wrap
    assign ovf = en_q && (tl_q == 32'hFFFF_FFFF);

    sync2 #(.W(SW_W)) u_sync2 (
        .clk   (clk),
        .reset (reset),
        .d_i   (switch),
        .q_o   (sw_sync)
    );

    // Next-state for the timer and bus registers; CPU writes win over counting and reload
    always_comb begin
        th_d  = we_th ? wdata : th_q;
        tl_d  = tl_q;
        if (en_q) begin
            tl_d = ovf ? th_q : tl_q + 32'd1;
        end
        if (we_tl) begin
            tl_d = wdata;
        end
        en_d  = en_q;
        ie_d  = ie_q;
        if_d  = if_q | (ovf & ie_q);
        if (we_tcon) begin
            en_d = wdata[TCON_EN];
            ie_d = wdata[TCON_IE];
            // A hardware set in the same cycle still wins, so no interrupt is lost
            if_d = wdata[TCON_IF] | (ovf & ie_q);
        end
        led_d = we_led ? wdata[LED_W-1:0] : led_q;
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            en_q   <= 1'b0;
            ie_q   <= 1'b0;
            if_q   <= 1'b0;
            led_q  <= '0;
            tick_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            en_q   <= en_d;
            ie_q   <= ie_d;
            if_q   <= if_d;
            led_q  <= led_d;
            tick_q <= tick_q + 32'd1;
        end
    end

    // Assemble the TCON read view with unused bits as zero
    always_comb begin
        tcon_val          = '0;
        tcon_val[TCON_EN] = en_q;
        tcon_val[TCON_IE] = ie_q;
        tcon_val[TCON_IF] = if_q;
    end

    // Read mux: selected register on a mapped load, otherwise zero
    always_comb begin
        rdata = '0;
        if (rd && hit) begin
            case (widx)
                W_TH:      rdata = th_q;
                W_TL:      rdata = tl_q;
                W_TCON:    rdata = tcon_val;
                W_LED:     rdata = 32'(led_q);
                W_SW:      rdata = 32'(sw_sync);
                W_SYSTICK: rdata = tick_q;
                default:   rdata = '0;
            endcase
        end
    end

    assign led    = led_q;
    assign irqout = ie_q & if_q;

endmodule

// File: tb/tb_mmio_timer_periph.sv
module tb_mmio_timer_periph;

    localparam logic [31:0] B = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  switch;
    logic [7:0]  led;
    logic        irqout;

    always #5 clk = ~clk;

    mmio_timer_periph #(.BASE(B), .LED_W(8), .SW_W(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .switch (switch),
        .led    (led),
        .irqout (irqout)
    );

    // Reference state, held as the programmer sees the registers
    logic [31:0] m_th, m_tl, m_tick;
    logic        m_en, m_ie, m_if;
    logic [7:0]  m_led;
    logic [7:0]  sw_hist[$];   // switch samples at the last two edges, oldest first

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_th = 0; m_tl = 0; m_tick = 0;
        m_en = 0; m_ie = 0; m_if = 0;
        m_led = 0;
        sw_hist = {8'h00, 8'h00};
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a < B || a > B + 32'd31) return 32'd0;
        case ((a - B) / 4)
            0: return m_th;
            1: return m_tl;
            2: return {29'd0, m_if, m_ie, m_en};
            3: return {24'd0, m_led};
            4: return {24'd0, sw_hist[0]};
            5: return m_tick;
            default: return 32'd0;
        endcase
    endfunction

    // Apply one bus cycle: check outputs mid-cycle, then advance the model over the edge
    task automatic step(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        bit          mapped;
        int          idx;
        bit          wrap;
        logic [31:0] nxt_tl;
        rd = r; wr = w; addr = a; wdata = d;
        @(negedge clk);
        chk("rdata", rdata, r ? m_read(a) : 32'd0);
        chk("irqout", {31'd0, irqout}, {31'd0, m_ie & m_if});
        chk("led", {24'd0, led}, {24'd0, m_led});
        mapped = (a >= B) && (a <= B + 32'd31);
        idx    = int'((a - B) / 4);
        wrap   = m_en && (m_tl == 32'hFFFF_FFFF);
        nxt_tl = !m_en ? m_tl : (wrap ? m_th : m_tl + 1);
        if (wrap && m_ie) m_if = 1;
        if (w && mapped) begin
            case (idx)
                0: m_th = d;
                1: nxt_tl = d;
                2: begin
                    m_if = d[2] | (wrap & m_ie);
                    m_en = d[0];
                    m_ie = d[1];
                end
                3: m_led = d[7:0];
                default: ;
            endcase
        end
        m_tl   = nxt_tl;
        m_tick = m_tick + 1;
        sw_hist.push_back(switch);
        void'(sw_hist.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic rd_at(input logic [4:0] ofs);
        step(1, 0, B + 32'(ofs), 32'd0);
    endtask

    task automatic wr_at(input logic [4:0] ofs, input logic [31:0] d);
        step(0, 1, B + 32'(ofs), d);
    endtask

    initial begin
        logic [31:0] a, d;
        int          pick;

        reset = 0; rd = 0; wr = 0; addr = 0; wdata = 0; switch = 0;
        model_reset();
        #1;
        chk("reset_irqout", {31'd0, irqout}, 32'd0);
        chk("reset_led", {24'd0, led}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1;

        // Reset values and unmapped accesses
        for (int i = 0; i < 6; i++) rd_at(5'(i * 4));
        step(1, 0, B + 32'h20, 0);
        step(1, 0, 32'h1000_0000, 0);
        step(1, 0, B + 32'h18, 0);
        wr_at(5'h14, 32'h1234_5678);
        rd_at(5'h14);
        wr_at(5'h10, 32'hFF);
        rd_at(5'h10);

        // Reload with IE=1, then acknowledge
        wr_at(5'h00, 32'hFFFF_FFFC);
        wr_at(5'h04, 32'hFFFF_FFFE);
        wr_at(5'h08, 32'd3);
        for (int i = 0; i < 4; i++) rd_at(5'h04);
        rd_at(5'h08);
        wr_at(5'h08, 32'd3);
        rd_at(5'h08);

        // Overflow with IE=0: reload only
        wr_at(5'h08, 32'd1);
        wr_at(5'h04, 32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) rd_at(5'h08);

        // TCON write lands in the overflow cycle
        wr_at(5'h08, 32'd3);
        wr_at(5'h04, 32'hFFFF_FFFE);
        rd_at(5'h04);
        wr_at(5'h08, 32'd3);
        rd_at(5'h08);
        wr_at(5'h08, 32'd3);

        // TL write lands in the overflow cycle
        wr_at(5'h04, 32'hFFFF_FFFE);
        rd_at(5'h04);
        wr_at(5'h04, 32'h10);
        rd_at(5'h04);
        rd_at(5'h04);

        // TH write lands in the overflow cycle
        wr_at(5'h04, 32'hFFFF_FFFE);
        rd_at(5'h04);
        wr_at(5'h00, 32'h0000_0100);
        rd_at(5'h04);
        rd_at(5'h00);

        // Simultaneous read and write shows the old value
        step(1, 1, B + 32'h0C, 32'h5A);
        rd_at(5'h0C);

        // LED and switch path
        wr_at(5'h0C, 32'hA5);
        switch = 8'h3C;
        for (int i = 0; i < 4; i++) rd_at(5'h10);

        // Randomized traffic, biased toward wrap-around of TL
        for (int n = 0; n < 3000; n++) begin
            pick = int'($urandom_range(0, 9));
            case (pick)
                6:       a = B + 32'h18 + 32'($urandom_range(0, 7));
                7:       a = $urandom;
                default: a = B + 32'(pick * 4) + 32'($urandom_range(0, 3));
            endcase
            d = $urandom;
            if (pick == 1 || pick == 0) d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            if (pick == 2) d = 32'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) switch = 8'($urandom);
            step(1'($urandom), 1'($urandom_range(0, 3) == 0), a, d);
        end

        // Asynchronous reset while the interrupt is pending
        wr_at(5'h0C, 32'h77);
        wr_at(5'h08, 32'd7);
        rd = 1; addr = B + 32'h04; wr = 0;
        @(negedge clk);
        chk("irq_before_reset", {31'd0, irqout}, 32'd1);
        #2 reset = 0;
        #1;
        chk("async_irqout", {31'd0, irqout}, 32'd0);
        chk("async_led", {24'd0, led}, 32'd0);
        chk("async_rdata", rdata, 32'd0);
        @(posedge clk);
        #1 reset = 1;
        model_reset();
        rd_at(5'h14);
        rd = 1; addr = B + 32'h14;
        @(negedge clk);
        chk("systick_first_edge", rdata, 32'd1);
        @(posedge clk);
        #1;
        m_tick = m_tick + 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
